// File: rtl/tetromino_pkg.sv
// Shared types, base shape table and rotation helper for the tetromino stamper.
package tetromino_pkg;

   typedef enum logic [2:0] {NONE, I, O, T, S, Z, J, L} piece_t;

   typedef logic [15:0] mask_t;

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} stamp_state_t;

   // Bit index = 4*row + col inside the 4x4 bounding box.
   localparam mask_t BASE_MASK [8] = '{
      16'h0000, 16'h00F0, 16'h0066, 16'h0072,
      16'h0036, 16'h0063, 16'h0071, 16'h0074
   };

   // One clockwise quarter turn: rotated(r,k) = base(3-k, r).
   function automatic mask_t rotate_cw(input mask_t m);
      mask_t r;
      r = '0;
      for (int row = 0; row < 4; row++) begin
         for (int col = 0; col < 4; col++) begin
            r[4*row + col] = m[4*(3-col) + row];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tetromino_shape_rom.sv
// Combinational lookup of a piece's 4x4 occupancy mask for a given id and rotation.
module tetromino_shape_rom
   import tetromino_pkg::*;
#(
   parameter int ID_W = 3
) (
   input  logic [ID_W-1:0] t_id,
   input  logic [1:0]      rot,
   output mask_t           mask
);

   logic  id_ok;
   mask_t base;
   mask_t stage [4];

   // Ids wider than the 3-bit shape table are "no shape" when any upper bit is set.
   generate
      if (ID_W > 3) begin : g_wide_id
         assign id_ok = ~|t_id[ID_W-1:3];
      end else begin : g_narrow_id
         assign id_ok = 1'b1;
      end
   endgenerate

   always_comb begin
      base = '0;
      if (id_ok) begin
         base = BASE_MASK[piece_t'(t_id[2:0])];
      end
   end

   assign stage[0] = base;

   generate
      for (genvar gi = 1; gi < 4; gi++) begin : g_rot
         assign stage[gi] = rotate_cw(stage[gi-1]);
      end
   endgenerate

   assign mask = stage[rot];

endmodule

// File: rtl/tetromino_stamper.sv
// Walks a rotated tetromino's 4x4 box, writing one board cell per clock with edge clipping.
module tetromino_stamper
   import tetromino_pkg::*;
#(
   parameter int COORD_W = 5,
   parameter int ID_W    = 3,
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               erase,
   input  logic [1:0]         rot,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   input  logic [ID_W-1:0]    t_id,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [ID_W-1:0]    out_id,
   output logic               wren,
   output logic               busy,
   output logic               done,
   output logic               clipped
);

   localparam logic [COORD_W:0] BOARD_W_L = (COORD_W+1)'(BOARD_W);
   localparam logic [COORD_W:0] BOARD_H_L = (COORD_W+1)'(BOARD_H);

   stamp_state_t       state_reg, state_next;
   logic               erase_reg, erase_next;
   logic [1:0]         rot_reg, rot_next;
   logic [COORD_W-1:0] x_reg, x_next;
   logic [COORD_W-1:0] y_reg, y_next;
   logic [ID_W-1:0]    id_reg, id_next;
   logic [3:0]         cnt_reg, cnt_next;
   logic               clip_reg, clip_next;

   mask_t              mask;
   logic [COORD_W:0]   ax, ay;
   logic               cell_set, in_board;

   tetromino_shape_rom #(
      .ID_W (ID_W)
   ) u_shape_rom (
      .t_id (id_reg),
      .rot  (rot_reg),
      .mask (mask)
   );

   // One extra bit keeps in_x+3 from wrapping back onto the board.
   assign ax       = {1'b0, x_reg} + (COORD_W+1)'(cnt_reg[1:0]);
   assign ay       = {1'b0, y_reg} + (COORD_W+1)'(cnt_reg[3:2]);
   assign cell_set = mask[cnt_reg];
   assign in_board = (ax < BOARD_W_L) && (ay < BOARD_H_L);

   always_comb begin
      state_next = state_reg;
      erase_next = erase_reg;
      rot_next   = rot_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      id_next    = id_reg;
      cnt_next   = cnt_reg;
      clip_next  = clip_reg;
      wren       = 1'b0;
      x          = '0;
      y          = '0;
      out_id     = '0;
      done       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               erase_next = erase;
               rot_next   = rot;
               x_next     = in_x;
               y_next     = in_y;
               id_next    = t_id;
               cnt_next   = '0;
               clip_next  = 1'b0;
               state_next = ST_SCAN;
            end
         end
         ST_SCAN: begin
            wren     = cell_set && in_board;
            x        = ax[COORD_W-1:0];
            y        = ay[COORD_W-1:0];
            out_id   = erase_reg ? '0 : id_reg;
            if (cell_set && !in_board) begin
               clip_next = 1'b1;
            end
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg == 4'd15) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign busy    = (state_reg != ST_IDLE);
   assign clipped = clip_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         erase_reg <= 1'b0;
         rot_reg   <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         id_reg    <= '0;
         cnt_reg   <= '0;
         clip_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         erase_reg <= erase_next;
         rot_reg   <= rot_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         id_reg    <= id_next;
         cnt_reg   <= cnt_next;
         clip_reg  <= clip_next;
      end
   end

endmodule
